// File: rtl/z80_bus_responder.sv
// Bus target for the Z80 core: a mirrored byte RAM plus a DATA/STATUS I/O port
// that bridges the CPU to host-side RX and TX byte FIFOs.
module z80_bus_responder #(
    parameter int         MEM_AW   = 12,
    parameter int         RX_DEPTH = 4,
    parameter int         TX_DEPTH = 4,
    parameter logic [7:0] IO_BASE  = 8'h10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fault
);

    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [7:0] PORT_DATA = IO_BASE;
    localparam logic [7:0] PORT_STAT = IO_BASE + 8'd1;

    logic [7:0] ram [2**MEM_AW];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [7:0] tx_mem [TX_DEPTH];

    logic [3:0]       strobe_prev_q, strobe_prev_d;
    logic [7:0]       bus_rdata_q, bus_rdata_d;
    logic             fault_q, fault_d;
    logic             rx_udf_q, rx_udf_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic [RX_PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [TX_PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;

    logic [3:0]        strobes;
    logic [3:0]        start;
    logic              conflict;
    logic              mem_rd_start, mem_wr_start, io_rd_start, io_wr_start;
    logic              is_data, is_stat;
    logic              rx_full, rx_empty, rx_push, rx_pop, rx_udf_set;
    logic              tx_full, tx_empty, tx_push, tx_pop, tx_req, tx_ovf_set;
    logic              stat_wr;
    logic [MEM_AW-1:0] ram_idx;
    logic [7:0]        ram_rdata;
    logic [7:0]        status;
    logic              unused_addr;

    assign unused_addr = &{1'b0, addr};

    // A start is a rising strobe; any cycle with two or more strobes high takes no start.
    assign strobes  = {mem_rd, mem_wr, io_rd, io_wr};
    assign conflict = (strobes & (strobes - 4'd1)) != 4'd0;
    assign start    = strobes & ~strobe_prev_q & {4{~conflict}};

    assign mem_rd_start = start[3] && !reset;
    assign mem_wr_start = start[2] && !reset;
    assign io_rd_start  = start[1] && !reset;
    assign io_wr_start  = start[0] && !reset;

    assign is_data = addr[7:0] == PORT_DATA;
    assign is_stat = addr[7:0] == PORT_STAT;

    assign ram_idx   = addr[MEM_AW-1:0];
    assign ram_rdata = ram[ram_idx];

    assign rx_full    = rx_cnt_q == RX_FULL_CNT;
    assign rx_empty   = rx_cnt_q == '0;
    assign rx_push    = rx_valid && !rx_full && !reset;
    assign rx_pop     = io_rd_start && is_data && !rx_empty;
    assign rx_udf_set = io_rd_start && is_data && rx_empty;

    // A full TX FIFO still takes a CPU byte when the host drains one the same cycle.
    assign tx_full    = tx_cnt_q == TX_FULL_CNT;
    assign tx_empty   = tx_cnt_q == '0;
    assign tx_pop     = !tx_empty && tx_ready && !reset;
    assign tx_req     = io_wr_start && is_data;
    assign tx_push    = tx_req && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_req && tx_full && !tx_pop;

    assign stat_wr = io_wr_start && is_stat;
    assign status  = {4'b0000, tx_ovf_q, rx_udf_q, !tx_full, !rx_empty};

    always_comb begin
        strobe_prev_d = strobes;
        fault_d       = fault_q | conflict;
        rx_udf_d      = rx_udf_set | (rx_udf_q & ~(stat_wr & bus_wdata[2]));
        tx_ovf_d      = tx_ovf_set | (tx_ovf_q & ~(stat_wr & bus_wdata[3]));

        bus_rdata_d = bus_rdata_q;
        if (mem_rd_start) begin
            bus_rdata_d = ram_rdata;
        end else if (io_rd_start) begin
            if (is_data) begin
                bus_rdata_d = rx_empty ? 8'hFF : rx_mem[rx_rd_ptr_q];
            end else if (is_stat) begin
                bus_rdata_d = status;
            end else begin
                bus_rdata_d = 8'hFF;
            end
        end
    end

    always_comb begin
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RX_PW'(1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RX_PW'(1) : rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TX_PW'(1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + TX_PW'(1) : tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_wr_start) begin
            ram[ram_idx] <= bus_wdata;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= rx_data;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= bus_wdata;
        end
    end

    // Previous-strobe registers reset high so a strobe held through reset is not a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_prev_q <= 4'b1111;
            bus_rdata_q   <= 8'h00;
            fault_q       <= 1'b0;
            rx_udf_q      <= 1'b0;
            tx_ovf_q      <= 1'b0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_cnt_q      <= '0;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_cnt_q      <= '0;
        end else begin
            strobe_prev_q <= strobe_prev_d;
            bus_rdata_q   <= bus_rdata_d;
            fault_q       <= fault_d;
            rx_udf_q      <= rx_udf_d;
            tx_ovf_q      <= tx_ovf_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_cnt_q      <= rx_cnt_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_cnt_q      <= tx_cnt_d;
        end
    end

    assign bus_rdata = bus_rdata_q;
    assign fault     = fault_q;
    assign rx_ready  = !rx_full;
    assign tx_valid  = !tx_empty;
    assign tx_data   = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_q];

endmodule

// File: tb/tb_z80_bus_responder.sv
// Scoreboard bench for z80_bus_responder: RAM, DATA/STATUS port, FIFOs, fault and reset.
module tb_z80_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        mem_rd, mem_wr, io_rd, io_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fault;

    int nchecks = 0;
    int nerr    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_model[$];
    logic [7:0] tx_model[$];

    z80_bus_responder dut (
        .clk(clk), .reset(reset), .addr(addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .io_rd(io_rd), .io_wr(io_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input bit is_io, input logic [15:0] a, output logic [7:0] got);
        addr = a;
        if (is_io) io_rd = 1'b1; else mem_rd = 1'b1;
        tick();
        got = bus_rdata;
        io_rd = 1'b0;
        mem_rd = 1'b0;
        tick();
    endtask

    task automatic cpu_write(input bit is_io, input logic [15:0] a, input logic [7:0] d);
        addr = a;
        bus_wdata = d;
        if (is_io) io_wr = 1'b1; else mem_wr = 1'b1;
        tick();
        io_wr = 1'b0;
        mem_wr = 1'b0;
        tick();
    endtask

    task automatic cpu_tx_write(input logic [7:0] d);
        if (tx_model.size() < 4) tx_model.push_back(d);
        cpu_write(1'b1, 16'h0010, d);
    endtask

    task automatic host_push(input logic [7:0] d);
        if (rx_model.size() < 4) rx_model.push_back(d);
        rx_data = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] rx_expect();
        if (rx_model.size() != 0) return rx_model.pop_front();
        return 8'hFF;
    endfunction

    task automatic test_reset();
        reset = 1'b1; addr = '0; mem_rd = 0; mem_wr = 0; io_rd = 0; io_wr = 0;
        bus_wdata = '0; rx_data = '0; rx_valid = 0; tx_ready = 0;
        tick(); tick();
        reset = 1'b0;
        nchecks++; if (bus_rdata !== 8'h00) begin nerr++; $display("FAIL rst_rdata: got %h want 00", bus_rdata); end
        nchecks++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
        nchecks++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        nchecks++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        nchecks++; if (fault !== 1'b0) begin nerr++; $display("FAIL rst_fault: got %b want 0", fault); end
        tick();
    endtask

    task automatic test_mem();
        logic [7:0] got, exp;
        cpu_write(1'b0, 16'h0123, 8'hA5);
        exp_q.push_back(8'hA5); cpu_read(1'b0, 16'h0123, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL mem_rd: got %h want %h", got, exp); end
        exp_q.push_back(8'hA5); cpu_read(1'b0, 16'h1123, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL mem_mirror: got %h want %h", got, exp); end
        cpu_write(1'b0, 16'h0FFF, 8'h3C);
        exp_q.push_back(8'h3C); cpu_read(1'b0, 16'hFFFF, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL mem_top_mirror: got %h want %h", got, exp); end
        exp_q.push_back(8'hA5); cpu_read(1'b0, 16'h0123, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL mem_keep: got %h want %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        exp_q.push_back(8'h5A);
        addr = 16'h0456; bus_wdata = 8'h5A; mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0; mem_rd = 1'b1;
        tick();
        exp = exp_q.pop_front();
        nchecks++; if (bus_rdata !== exp) begin nerr++; $display("FAIL b2b_rd_after_wr: got %h want %h", bus_rdata, exp); end
        mem_rd = 1'b0;
        tick();
    endtask

    task automatic test_held_strobe();
        logic [7:0] got, exp;
        host_push(8'h41);
        host_push(8'h42);
        exp_q.push_back(rx_expect());
        addr = 16'h0010; io_rd = 1'b1;
        repeat (5) tick();
        got = bus_rdata;
        io_rd = 1'b0;
        tick();
        exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL held_pop: got %h want %h", got, exp); end
        exp_q.push_back(8'h03); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL held_status: got %h want %h", got, exp); end
        exp_q.push_back(rx_expect()); cpu_read(1'b1, 16'h0010, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL held_second: got %h want %h", got, exp); end
        exp_q.push_back(8'h02); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL held_drained: got %h want %h", got, exp); end
    endtask

    task automatic test_rx_underflow();
        logic [7:0] got, exp;
        exp_q.push_back(rx_expect()); cpu_read(1'b1, 16'h0010, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL udf_data: got %h want %h", got, exp); end
        exp_q.push_back(8'h06); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL udf_status: got %h want %h", got, exp); end
        cpu_write(1'b1, 16'h0011, 8'h04);
        exp_q.push_back(8'h02); cpu_read(1'b1, 16'hAB11, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL udf_clear: got %h want %h", got, exp); end
        exp_q.push_back(8'hFF); cpu_read(1'b1, 16'h0012, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL unmapped_port: got %h want %h", got, exp); end
        for (int i = 0; i < 5; i++) host_push(8'h50 + 8'(i));
        nchecks++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rx_expect()); cpu_read(1'b1, 16'h0010, got); exp = exp_q.pop_front();
            nchecks++; if (got !== exp) begin nerr++; $display("FAIL rx_full_order[%0d]: got %h want %h", i, got, exp); end
        end
        exp_q.push_back(8'h02); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL rx_full_status: got %h want %h", got, exp); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] got, exp;
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) cpu_tx_write(8'(i));
        nchecks++; if ({tx_valid, tx_data} !== 9'h101) begin nerr++; $display("FAIL ovf_head: got %b/%h want 1/01", tx_valid, tx_data); end
        exp_q.push_back(8'h08); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL ovf_status: got %h want %h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            exp = tx_model.pop_front();
            nchecks++; if ({tx_valid, tx_data} !== {1'b1, exp}) begin nerr++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h", i, tx_valid, tx_data, exp); end
            tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        end
        nchecks++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL ovf_empty: got %b want 0", tx_valid); end
        cpu_write(1'b1, 16'h0011, 8'h08);
        exp_q.push_back(8'h02); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL ovf_clear: got %h want %h", got, exp); end
    endtask

    task automatic test_tx_full_concurrent();
        logic [7:0] got, exp;
        for (int i = 1; i <= 4; i++) cpu_tx_write(8'h11 * 8'(i));
        exp_q.push_back(8'h00); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL tx_full_status: got %h want %h", got, exp); end
        addr = 16'h0010; bus_wdata = 8'h77; io_wr = 1'b1; tx_ready = 1'b1;
        void'(tx_model.pop_front());
        tx_model.push_back(8'h77);
        tick();
        io_wr = 1'b0; tx_ready = 1'b0;
        tick();
        exp_q.push_back(8'h00); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL conc_no_ovf: got %h want %h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            exp = tx_model.pop_front();
            nchecks++; if ({tx_valid, tx_data} !== {1'b1, exp}) begin nerr++; $display("FAIL conc_drain[%0d]: got %b/%h want 1/%h", i, tx_valid, tx_data, exp); end
            tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        end
    endtask

    task automatic test_fault();
        logic [7:0] got, exp;
        cpu_write(1'b0, 16'h0010, 8'hC3);
        exp_q.push_back(8'hA5); cpu_read(1'b0, 16'h0123, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL fault_pre: got %h want %h", got, exp); end
        nchecks++; if (fault !== 1'b0) begin nerr++; $display("FAIL fault_clear_before: got %b want 0", fault); end
        addr = 16'h0010; bus_wdata = 8'h99; mem_rd = 1'b1; io_wr = 1'b1;
        tick();
        nchecks++; if (fault !== 1'b1) begin nerr++; $display("FAIL fault_set: got %b want 1", fault); end
        nchecks++; if (bus_rdata !== 8'hA5) begin nerr++; $display("FAIL fault_no_read: got %h want a5", bus_rdata); end
        mem_rd = 1'b0; io_wr = 1'b0;
        tick();
        nchecks++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL fault_no_tx: got %b want 0", tx_valid); end
        exp_q.push_back(8'hC3); cpu_read(1'b0, 16'h0010, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL fault_ram: got %h want %h", got, exp); end
        exp_q.push_back(8'h02); cpu_read(1'b1, 16'h0011, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL fault_status: got %h want %h", got, exp); end
        nchecks++; if (fault !== 1'b1) begin nerr++; $display("FAIL fault_sticky: got %b want 1", fault); end
    endtask

    task automatic test_reset_held();
        logic [7:0] got, exp;
        cpu_tx_write(8'h5E);
        addr = 16'h0123; mem_rd = 1'b1; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tx_model.delete();
        rx_model.delete();
        tick(); tick();
        nchecks++; if (bus_rdata !== 8'h00) begin nerr++; $display("FAIL rsth_no_start: got %h want 00", bus_rdata); end
        nchecks++; if (fault !== 1'b0) begin nerr++; $display("FAIL rsth_fault: got %b want 0", fault); end
        nchecks++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rsth_tx_flush: got %b want 0", tx_valid); end
        mem_rd = 1'b0;
        tick();
        exp_q.push_back(8'hA5); cpu_read(1'b0, 16'h0123, got); exp = exp_q.pop_front();
        nchecks++; if (got !== exp) begin nerr++; $display("FAIL rsth_ram_kept: got %h want %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_mem();
        test_back_to_back();
        test_held_strobe();
        test_rx_underflow();
        test_tx_overflow();
        test_tx_full_concurrent();
        test_fault();
        test_reset_held();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Bus target on the far side of the Z80 core's memory/IO strobe interface. It answers `mem_rd`/`mem_wr` from an internal byte RAM and `io_rd`/`io_wr` from a two-register I/O port. That port bridges the CPU to a host byte stream through an RX FIFO (host→CPU) and a TX FIFO (CPU→host). It sits between the sequencer's bus outputs and the rest of the SoC or testbench, so the core can run against a self-contained memory and console.

## Interface
- `MEM_AW`, 12: RAM address width. RAM holds 2^MEM_AW bytes and mirrors across the 16-bit space.
- `RX_DEPTH`, 4: RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `IO_BASE`, 8'h10: I/O port base; must be even.
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous reset, active-high.
- `addr`  in  16  bus address.
- `mem_rd`, `mem_wr`, `io_rd`, `io_wr`  in  1 each  strobes from the sequencer.
- `bus_wdata`  in  8  write data.
- `bus_rdata`  out  8  read data, registered.
- `rx_data`  in  8  host byte to the CPU.
- `rx_valid`  in  1  host byte present.
- `rx_ready`  out  1  RX FIFO can accept a byte.
- `tx_data`  out  8  TX FIFO head.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  host accepts the head.
- `fault`  out  1  sticky flag: bus protocol violation.

## Operation
- Start detection: per-strobe "previous" registers.
  - A start is a strobe that is high now and was low last cycle.
  - All actions happen once per start. Holding a strobe does not repeat the action.
- Strobe conflict: if more than one strobe is high in a cycle, that is a conflict.
  - No start is taken on that cycle.
  - `fault` is set and stays set until `reset`.
- Memory read start: `bus_rdata` ← RAM[`addr[MEM_AW-1:0]`].
- Memory write start: RAM[`addr[MEM_AW-1:0]`] ← `bus_wdata`.
- I/O decode uses `addr[7:0]` only.
- Port `IO_BASE+0`, DATA:
  - Read: pops the RX head into `bus_rdata`. If RX is empty, returns 8'hFF, does not pop, and sets `rx_underflow`.
  - Write: pushes `bus_wdata` to TX. If TX is full, drops the byte and sets `tx_overflow`.
- Port `IO_BASE+1`, STATUS:
  - Read returns {4'b0, `tx_overflow`, `rx_underflow`, !tx_full, !rx_empty}.
  - Write: a 1 in bit 2 clears `rx_underflow`; a 1 in bit 3 clears `tx_overflow`.
- Any other port: reads return 8'hFF; writes are ignored.
- `bus_rdata` holds its value until the next read start of either kind.
- Host side:
  - RX push when `rx_valid && rx_ready`, with `rx_ready = !rx_full`.
  - TX pop when `tx_valid && tx_ready`, with `tx_valid = !tx_empty` and `tx_data` = head.
- Occupancy counters are $clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- A CPU pop and a host push in the same cycle (and likewise host pop with CPU push) both take effect and occupancy is unchanged.
  - When full, a simultaneous pop and push is allowed on TX: the CPU write is accepted if the host pops that cycle.
  - On RX, a full FIFO deasserts `rx_ready` regardless of a same-cycle CPU pop.
- Sticky flag set and clear in the same cycle: set wins.

## Timing
- Reset values:
  - `bus_rdata` = 8'h00; `rx_ready` = 1; `tx_valid` = 0; `tx_data` = 8'h00; `fault` = 0.
  - Both FIFOs are empty; `rx_underflow` and `tx_overflow` are 0.
  - RAM is not cleared.
- Reset sets all previous-strobe registers to 1. A strobe held high through reset release is therefore not a start; it must fall and rise again.
- Read latency: the start is sampled at edge N and `bus_rdata` is valid after edge N, i.e. in cycle N+1 while the strobe is still held.
- Write: RAM, FIFO and flag effects are visible from cycle N+1.
  - A memory read starting the cycle after a write to the same address returns the new byte.
- Host push at edge N: the byte is readable by a CPU start sampled at edge N+1. STATUS bit0 = 1 in cycle N+1.
- CPU TX push at edge N: `tx_valid` = 1 in cycle N+1.
- Reset asserted mid-operation aborts everything. FIFO contents are lost; a partial RAM write cannot occur because writes are single-edge.

## Test plan
- Memory write/read:
  - mem_wr start at addr 16'h0123 with data 8'hA5, then mem_rd start at 16'h0123 → `bus_rdata` = 8'hA5 next cycle.
  - mem_rd at 16'h1123 (mirror, MEM_AW=12) → 8'hA5.
- Held strobe: io_rd on DATA held 5 cycles with RX holding 8'h41, 8'h42 → exactly one pop; `bus_rdata` = 8'h41; STATUS bit0 still 1.
- RX underflow:
  - DATA read with RX empty → 8'hFF; STATUS reads 8'h06 (TX not full, underflow set).
  - io_wr STATUS with 8'h04 → STATUS reads 8'h02.
- TX overflow: 5 DATA writes 8'h01..8'h05 with `tx_ready` = 0 → `tx_valid` = 1, `tx_data` = 8'h01, STATUS bit3 = 1. Then `tx_ready` = 1 drains 01,02,03,04 in order.
- Full-FIFO concurrency: TX full while the host pops and the CPU writes 8'h77 in the same cycle → 8'h77 accepted, no overflow.
- Fault and reset:
  - mem_rd and io_wr high together → `fault` = 1; RAM and FIFOs unchanged.
  - `reset` with mem_rd held high, then release → no read start until mem_rd toggles; `fault` = 0 and `bus_rdata` = 8'h00.
